inst_fetch_buf: RTL and testbench
=================================

Name: inst_fetch_buf

Overview:
- Fetch stage directly downstream of the PC register in the bittyCore pipeline.
- Takes the current PC and fetch-enable and issues word requests on a req/gnt/rvalid instruction-memory port.
- Buffers returned instructions with their addresses in a small in-order FIFO and presents them to decode with a valid/ready handshake.
- Raises a stall request back to the PC register when it cannot accept the PC, and discards in-flight fetches on branch flush.

Parameters:
DEPTH, 2, FIFO entries and maximum fetches in flight; power of two, at least 2
ADDR_W, 32, instruction address width (`InstAddrBus)
DATA_W, 32, instruction width (`InstBus)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low (0 = reset)
pc_i  input  ADDR_W  current PC from PC register
ce_i  input  1  fetch enable from PC register
flush_i  input  1  branch taken / redirect; kills buffered and in-flight fetches
stallreq_o  output  1  PC hold request; drives stalled[0] path
imem_req_o  output  1  instruction memory request
imem_addr_o  output  ADDR_W  request address, word aligned
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  read data valid; responses return in order
imem_rdata_i  input  DATA_W  read data
inst_valid_o  output  1  instruction available to decode
inst_o  output  DATA_W  instruction at FIFO head
inst_addr_o  output  ADDR_W  address of inst_o
id_ready_i  input  1  decode accepts head this cycle

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty; outstanding count = 0; discard count = 0; address-tracking queue empty. All outputs are 0 while in reset and afterwards until driven by state.
- Reset mid-operation drops everything. Responses from old requests that return after reset release are ignored, because outstanding = 0.
- Credit rule:
  - occ = FIFO entries; outst = granted requests without response.
  - Issue is allowed only when occ + outst < DEPTH.
  - This guarantees every response has a FIFO slot, so a push into a full FIFO is impossible.
- Request generation (combinational):
  - imem_req_o = ce_i & ~flush_i & credit_ok.
  - imem_addr_o = {pc_i[ADDR_W-1:2], 2'b00}.
- Grant: on imem_req_o & imem_gnt_i, the address is pushed into a DEPTH-entry in-order address queue and outst increments.
- stallreq_o = ce_i & ~flush_i & ~(imem_req_o & imem_gnt_i). It is combinational, so the PC holds until its fetch is granted.
  - stallreq_o is 0 in a flush cycle, so the PC register always takes the branch address.
- Response (imem_rvalid_i):
  - outst decrements and the address queue pops.
  - If discard count > 0: discard count decrements and the data is dropped.
  - Otherwise {addr, rdata} is written to the FIFO.
  - rvalid while outst = 0 is a protocol error and is ignored.
- Latency:
  - Grant at cycle N, earliest rvalid at N+1, inst_valid_o at N+2.
  - There is no bypass from imem_rdata_i to inst_o.
- Output:
  - inst_valid_o = occ != 0.
  - inst_o and inst_addr_o come from the FIFO head registers and are stable while valid & ~ready.
  - Pop on inst_valid_o & id_ready_i.
- Simultaneous push and pop: occ is unchanged and both the read and write pointers advance.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap naturally. occ and outst counters are log2(DEPTH)+1 bits.
- Flush (flush_i=1):
  - FIFO is emptied next cycle (occ = 0, pointers equal), including any same-cycle push.
  - Same-cycle pop from decode is ignored.
  - discard count <= outst after this cycle's response accounting. A response arriving in the flush cycle is itself dropped and not counted.
  - No grant can occur in a flush cycle.
- Flush with discard count already nonzero: the same rule applies. The new value equals the remaining outstanding count.

Decomposition:
- Shared package/defines (bitty_defs.v): `InstAddrBus, `InstBus, `ZeroWord, and the reset level/enable macros for the active-low reset. Add `FetchBufDepth as the default for DEPTH.
- One sub-module, fetch_fifo: a parameterised synchronous FIFO (width, depth) with push/pop/clear and full/empty/count.
  - Instantiated twice: once as the address queue (ADDR_W wide), once as the instruction buffer (ADDR_W+DATA_W wide).
  - The credit, discard and stall logic stays in inst_fetch_buf.

Test Plan:
- Reset then ce_i=1, pc_i=0x0 with gnt always 1 and 1-cycle rvalid returning 0x00000013 -> imem_req_o=1 with addr 0x0. inst_valid_o=1 two cycles after the grant, with inst_o=0x00000013 and inst_addr_o=0x0. stallreq_o=0 throughout.
- Back-pressure: id_ready_i=0, DEPTH=2, fetch 0x0 and 0x4 -> after two grants imem_req_o=0 and stallreq_o=1. The FIFO holds 0x0 then 0x4. Raising id_ready_i drains them in order and requests resume at 0x8.
- Grant delay: imem_gnt_i=0 for 3 cycles with pc_i=0x10 -> stallreq_o=1 for those 3 cycles and imem_addr_o stays 0x10. Grant in the 4th cycle drops stallreq_o.
- Flush with 2 in flight, responses 3 cycles late: assert flush_i one cycle -> both responses (0x20, 0x24) are dropped and the FIFO stays empty. stallreq_o=0 in the flush cycle. The next fetch at branch target 0x100 is delivered with inst_addr_o=0x100.
- Flush coincident with rvalid and id_ready_i pop, FIFO occ=1 -> next cycle occ=0, discard count = remaining outst, and no stale instruction is ever valid.
- Async reset asserted mid-transfer (outst=1, occ=1) between clock edges -> outputs go to 0 immediately. A late rvalid after release is ignored and inst_valid_o stays 0.

Source files
------------

// File: rtl/inst_fetch_buf_pkg.sv
// Shared constants for the bittyCore instruction fetch buffer.
//   INST_ADDR_W     : instruction address width
//   INST_W          : instruction width
//   ZERO_WORD       : all-zero instruction word
//   FETCH_BUF_DEPTH : default FIFO depth and in-flight fetch limit
//   RST_ENABLE      : level of rst that holds the block in reset (active-low)
package inst_fetch_buf_pkg;

    localparam int          INST_ADDR_W     = 32;
    localparam int          INST_W          = 32;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
    localparam int          FETCH_BUF_DEPTH = 2;
    localparam logic        RST_ENABLE      = 1'b0;
    localparam logic        RST_DISABLE     = 1'b1;

endpackage

// File: rtl/inst_fetch_buf_if.sv
// Instruction memory port (req/gnt/rvalid).
//   req    : fetch request, held until gnt
//   addr   : word-aligned request address
//   gnt    : request accepted this cycle
//   rvalid : read data valid, responses return in request order
//   rdata  : read data
// master = fetch side, slave = memory side.
interface inst_fetch_buf_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/inst_fetch_buf_fifo.sv
// fetch_fifo: synchronous in-order FIFO with clear.
//   clk, rst     : clock, asynchronous active-low reset (control state only)
//   push, wdata  : write an entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   clear        : empty the FIFO; wins over a same-cycle push/pop
//   rdata        : head entry
//   full, empty  : occupancy flags
//   count        : number of stored entries
module fetch_fifo
    import inst_fetch_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d = cnt_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf: fetch stage between the PC register and decode.
//   clk, rst                 : clock, asynchronous active-low reset
//   pc_i, ce_i               : current PC and fetch enable from the PC register
//   flush_i                  : redirect; kills buffered and in-flight fetches
//   stallreq_o               : hold the PC until its fetch is granted
//   imem                     : instruction memory port (master side)
//   inst_valid_o, inst_o,
//   inst_addr_o, id_ready_i  : valid/ready handshake towards decode
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int DEPTH  = FETCH_BUF_DEPTH,
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DATA_W = INST_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                ce_i,
    input  logic                flush_i,
    output logic                stallreq_o,
    inst_fetch_buf_if.master    imem,
    output logic                inst_valid_o,
    output logic [DATA_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   inst_addr_o,
    input  logic                id_ready_i
);
    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);

    logic [CNT_W-1:0]         occ, outst;
    logic [CNT_W-1:0]         disc_q, disc_d;
    logic [CNT_W:0]           in_use;
    logic                     in_reset, credit_ok, grant, rsp, push, pop;
    logic                     aq_full, aq_empty, ib_full, ib_empty;
    logic [ADDR_W-1:0]        rsp_addr;
    logic [ADDR_W+DATA_W-1:0] head;
    logic                     unused_sig;

    // Outputs driven from ports are forced low while the reset is held.
    assign in_reset = (rst == RST_ENABLE);

    // Every granted fetch is guaranteed a FIFO slot: buffered + in flight
    // never exceeds DEPTH, so the instruction buffer can never overflow.
    assign in_use    = {1'b0, occ} + {1'b0, outst};
    assign credit_ok = (in_use < DEPTH_C);

    assign imem.req   = ~in_reset & ce_i & ~flush_i & credit_ok;
    assign imem.addr  = in_reset ? '0 : {pc_i[ADDR_W-1:2], 2'b00};
    assign grant      = imem.req & imem.gnt;
    assign stallreq_o = ~in_reset & ce_i & ~flush_i & ~grant;

    // A response with nothing outstanding (e.g. from before a reset) is ignored.
    assign rsp  = imem.rvalid & ~aq_empty;
    assign push = rsp & ~flush_i & (disc_q == '0);
    assign pop  = inst_valid_o & id_ready_i & ~flush_i;

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_addr_q (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .pop   (rsp),
        .clear (1'b0),
        .wdata (imem.addr),
        .rdata (rsp_addr),
        .full  (aq_full),
        .empty (aq_empty),
        .count (outst)
    );

    fetch_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_inst_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush_i),
        .wdata ({rsp_addr, imem.rdata}),
        .rdata (head),
        .full  (ib_full),
        .empty (ib_empty),
        .count (occ)
    );

    // On flush, everything still outstanding after this cycle's response must
    // be thrown away; no grant can happen in a flush cycle.
    always_comb begin
        disc_d = disc_q;
        if (flush_i)
            disc_d = outst - {{(CNT_W-1){1'b0}}, rsp};
        else if (rsp && (disc_q != '0))
            disc_d = disc_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) disc_q <= '0;
        else                   disc_q <= disc_d;
    end

    assign inst_valid_o = ~ib_empty;
    assign inst_o       = inst_valid_o ? head[DATA_W-1:0] : ZERO_WORD[DATA_W-1:0];
    assign inst_addr_o  = inst_valid_o ? head[ADDR_W+DATA_W-1:DATA_W] : '0;

    assign unused_sig = ^{aq_full, ib_full, pc_i[1:0]};
endmodule

// File: tb/tb_inst_fetch_buf.sv
module tb_inst_fetch_buf;
    localparam int DEPTH = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          killed;
    } pend_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] pc_i;
    logic          ce_i, flush_i, id_ready_i;
    logic          stallreq_o, inst_valid_o;
    logic [DW-1:0] inst_o;
    logic [AW-1:0] inst_addr_o;

    inst_fetch_buf_if #(.ADDR_W(AW), .DATA_W(DW)) imem_if ();

    inst_fetch_buf #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .flush_i      (flush_i),
        .stallreq_o   (stallreq_o),
        .imem         (imem_if),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .id_ready_i   (id_ready_i)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    bit          inject_rv = 0;
    bit          auto_pc   = 0;
    pend_t       pending[$];
    logic [63:0] exp_q[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return 32'h0000_0013 ^ (a << 8);
    endfunction

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Memory: responds in order, lat cycles after the grant.
    initial begin
        imem_if.rvalid = 0;
        imem_if.rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (inject_rv) begin
                imem_if.rvalid = 1;
                imem_if.rdata  = 32'hDEAD_BEEF;
            end else if (pending.size() != 0 && pending[0].due <= cyc) begin
                imem_if.rvalid = 1;
                imem_if.rdata  = data_of(pending[0].addr);
            end else begin
                imem_if.rvalid = 0;
                imem_if.rdata  = '0;
            end
        end
    end

    // Scoreboard: checks this cycle's outputs, then applies this cycle's events.
    initial begin
        bit    exp_req, exp_stall;
        pend_t p;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk_eq("rst_req", imem_if.req, 0);
                chk_eq("rst_addr", imem_if.addr, 0);
                chk_eq("rst_stall", stallreq_o, 0);
                chk_eq("rst_valid", inst_valid_o, 0);
                chk_eq("rst_inst", inst_o, 0);
                chk_eq("rst_inst_addr", inst_addr_o, 0);
                pending.delete();
                exp_q.delete();
            end else begin
                exp_req   = ce_i && !flush_i && (pending.size() + exp_q.size() < DEPTH);
                exp_stall = ce_i && !flush_i && !(exp_req && imem_if.gnt);
                chk_eq("req", imem_if.req, exp_req);
                chk_eq("stall", stallreq_o, exp_stall);
                if (exp_req) chk_eq("req_addr", imem_if.addr, {pc_i[31:2], 2'b00});
                chk_eq("valid", inst_valid_o, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    chk_eq("inst", inst_o, exp_q[0][31:0]);
                    chk_eq("inst_addr", inst_addr_o, exp_q[0][63:32]);
                    if (id_ready_i && !flush_i) void'(exp_q.pop_front());
                end
                if (imem_if.rvalid && pending.size() != 0) begin
                    p = pending.pop_front();
                    if (!p.killed && !flush_i) exp_q.push_back({p.addr, data_of(p.addr)});
                end
                if (exp_req && imem_if.gnt)
                    pending.push_back('{addr: {pc_i[31:2], 2'b00}, due: cyc + lat, killed: 1'b0});
                if (flush_i) begin
                    exp_q.delete();
                    foreach (pending[i]) pending[i].killed = 1'b1;
                end
            end
        end
    end

    // Emulates the PC register: advance by 4 whenever the fetch was taken.
    task automatic tick();
        bit adv;
        @(negedge clk);
        adv = ce_i && !flush_i && !stallreq_o;
        @(posedge clk);
        #1;
        if (auto_pc && adv) pc_i = pc_i + 32'd4;
    endtask

    task automatic drain(input int n);
        ce_i       = 0;
        flush_i    = 0;
        id_ready_i = 1;
        repeat (n) tick();
    endtask

    task automatic wait_valid_addr(input string tag, input logic [31:0] want);
        bit found = 0;
        for (int n = 0; n < 16 && !found; n++) begin
            #3;
            if (inst_valid_o) begin
                found = 1;
                chk_eq(tag, inst_addr_o, want);
            end
            tick();
        end
        chk_eq({tag, "_seen"}, found, 1);
    endtask

    initial begin
        bit found;
        rst = 0; pc_i = '0; ce_i = 0; flush_i = 0; id_ready_i = 0;
        imem_if.gnt = 0;
        repeat (3) tick();

        // Basic fetch at 0x0, 1-cycle memory
        rst = 1; ce_i = 1; pc_i = 32'h0; imem_if.gnt = 1; id_ready_i = 1; auto_pc = 1; lat = 1;
        #3;
        chk_eq("t1_req", imem_if.req, 1);
        chk_eq("t1_addr", imem_if.addr, 32'h0);
        chk_eq("t1_stall", stallreq_o, 0);
        tick();
        #3;
        chk_eq("t1_valid_n1", inst_valid_o, 0);
        tick();
        #3;
        chk_eq("t1_valid_n2", inst_valid_o, 1);
        chk_eq("t1_inst", inst_o, 32'h0000_0013);
        chk_eq("t1_inst_addr", inst_addr_o, 32'h0);
        repeat (8) tick();
        drain(6);

        // Back-pressure fills buffer and credits
        pc_i = 32'h0; ce_i = 1; id_ready_i = 0;
        repeat (4) tick();
        #3;
        chk_eq("t2_req", imem_if.req, 0);
        chk_eq("t2_stall", stallreq_o, 1);
        chk_eq("t2_head", inst_addr_o, 32'h0);
        id_ready_i = 1;
        found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            if (n != 0) #3;
            if (imem_if.req) begin
                found = 1;
                chk_eq("t2_resume_addr", imem_if.addr, 32'h8);
            end
            tick();
        end
        chk_eq("t2_resume_seen", found, 1);
        drain(6);

        // Grant delayed 3 cycles
        pc_i = 32'h10; ce_i = 1; imem_if.gnt = 0;
        for (int n = 0; n < 3; n++) begin
            #3;
            chk_eq("t3_stall", stallreq_o, 1);
            chk_eq("t3_addr", imem_if.addr, 32'h10);
            tick();
        end
        imem_if.gnt = 1;
        #3;
        chk_eq("t3_stall_gnt", stallreq_o, 0);
        chk_eq("t3_req_gnt", imem_if.req, 1);
        tick();
        drain(6);

        // Flush with two fetches in flight, 3-cycle memory
        lat = 3; pc_i = 32'h20; ce_i = 1;
        repeat (2) tick();
        flush_i = 1; pc_i = 32'h100;
        #3;
        chk_eq("t4_stall_flush", stallreq_o, 0);
        chk_eq("t4_req_flush", imem_if.req, 0);
        tick();
        flush_i = 0;
        wait_valid_addr("t4_target", 32'h100);
        drain(10);

        // Flush coincident with response and decode pop
        lat = 1; pc_i = 32'h200; ce_i = 1; id_ready_i = 0;
        repeat (2) tick();
        flush_i = 1; id_ready_i = 1; pc_i = 32'h300;
        #3;
        chk_eq("t5_valid_pre", inst_valid_o, 1);
        tick();
        flush_i = 0;
        #3;
        chk_eq("t5_valid_post", inst_valid_o, 0);
        tick();
        wait_valid_addr("t5_target", 32'h300);
        drain(8);

        // Asynchronous reset with one outstanding and one buffered
        lat = 1; pc_i = 32'h400; ce_i = 1; id_ready_i = 0; auto_pc = 0;
        tick();
        lat = 6;
        tick();
        #1;
        rst = 0;
        #1;
        chk_eq("t6_valid", inst_valid_o, 0);
        chk_eq("t6_inst", inst_o, 0);
        chk_eq("t6_inst_addr", inst_addr_o, 0);
        chk_eq("t6_req", imem_if.req, 0);
        chk_eq("t6_stall", stallreq_o, 0);
        tick();
        tick();
        rst = 1; ce_i = 0;
        tick();
        inject_rv = 1;
        tick();
        inject_rv = 0;
        for (int n = 0; n < 4; n++) begin
            #3;
            chk_eq("t6_late_valid", inst_valid_o, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
